// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] digit_t;

  // Ceiling log2 with a minimum of 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_4_7.sv
// Hex nibble to active-low 7-segment pattern {a,b,c,d,e,f,g}.
module decoder_4_7
  import seg_pkg::*;
(
  input  digit_t     value,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (value)
      4'h0: seg_c = 7'b0000001;
      4'h1: seg_c = 7'b1001111;
      4'h2: seg_c = 7'b0010010;
      4'h3: seg_c = 7'b0000110;
      4'h4: seg_c = 7'b1001100;
      4'h5: seg_c = 7'b0100100;
      4'h6: seg_c = 7'b0100000;
      4'h7: seg_c = 7'b0001111;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0000100;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b1100000;
      4'hC: seg_c = 7'b0110001;
      4'hD: seg_c = 7'b1000010;
      4'hE: seg_c = 7'b0110000;
      4'hF: seg_c = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with
// leading-zero blanking and a one-cycle dead time between digit slots.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [3:0]          wr_data,
  input  logic [N_DIGITS-1:0] digit_en,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic                lz_blank,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int unsigned IDX_W = clog2(N_DIGITS);
  localparam int unsigned DIV_W = clog2(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  digit_t           digits [N_DIGITS];

  logic             tick_c;
  logic             wr_ok_c;
  logic [IDX_W-1:0] msd_c;
  logic             lz_c;
  logic             show_c;
  digit_t           cur_c;
  logic [6:0]       dec_c;

  assign tick_c  = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign wr_ok_c = wr_en && ({1'b0, wr_addr} < 4'(N_DIGITS));
  assign cur_c   = digits[idx];

  // Slot divider and scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Digit register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_DIGITS); i++) digits[i] <= '0;
    end else if (wr_ok_c) begin
      digits[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Highest nonzero digit; stays 0 when every digit is zero.
  always_comb begin
    msd_c = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digits[i] != '0) msd_c = IDX_W'(i);
    end
  end

  // Digit 0 can never exceed msd, so it is never leading-zero blanked.
  assign lz_c   = lz_blank && (idx > msd_c);
  assign show_c = digit_en[idx] && !(lz_c && !dp_in[idx]);

  decoder_4_7 u_dec (
    .value (cur_c),
    .seg_c (dec_c)
  );

  // Output register; the tick cycle is forced dark to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (!tick_c && show_c) begin
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= lz_c ? SEG_BLANK : dec_c;
      dp  <= ~dp_in[idx];
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-count reference model queues the
// expected {an,seg,dp} per edge and a negedge monitor compares.
module tb_seg_scan_ctrl;

  localparam int ND = 8;
  localparam int TD = 4;
  localparam logic [15:0] RST_VAL = {8'hFF, 7'h7F, 1'b1};
  localparam logic [6:0] DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic [ND-1:0] digit_en = '1;
  logic [ND-1:0] dp_in = '0;
  logic          lz_blank = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_ctrl #(.N_DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .digit_en (digit_en),
    .dp_in    (dp_in),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Reference model: t = edges since reset release; slot and dead time follow from t.
  logic [3:0]  m_digits [ND];
  logic [15:0] exp_q [$];
  int          t = 0;
  int          m_d, m_msd;
  bit          m_tick, m_lz;
  logic [15:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < ND; i++) m_digits[i] = '0;
      exp_q.delete();
    end else begin
      m_d    = (t / TD) % ND;
      m_tick = (t % TD) == TD - 1;
      m_msd  = 0;
      for (int i = 0; i < ND; i++) if (m_digits[i] != 0) m_msd = i;
      m_lz   = lz_blank && (m_d > m_msd);
      if (m_tick || !digit_en[m_d] || (m_lz && !dp_in[m_d]))
        m_exp = RST_VAL;
      else
        m_exp = {~(8'h01 << m_d), (m_lz ? 7'h7F : DEC[m_digits[m_d]]), ~dp_in[m_d]};
      exp_q.push_back(m_exp);
      if (wr_en && wr_addr < ND) m_digits[wr_addr] = wr_data;
      t++;
    end
  end

  // Monitor: outputs hold reset values until the first post-reset edge queues an entry.
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (!rst_n || exp_q.size() == 0) mon_exp = RST_VAL;
    else mon_exp = exp_q.pop_front();
    n_tests++;
    if ({an, seg, dp} !== mon_exp) begin
      n_fail++;
      $display("FAIL out @%0t: got an=%h seg=%b dp=%b, need an=%h seg=%b dp=%b",
               $time, an, seg, dp, mon_exp[15:8], mon_exp[7:1], mon_exp[0]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(12);

    // Full scan of 0..7.
    for (int i = 0; i < ND; i++) wr(3'(i), 4'(i));
    step(40);

    // Leading-zero blanking with 00000123, then all zeros.
    for (int i = 0; i < ND; i++) wr(3'(i), (i < 3) ? 4'(3 - i) : 4'h0);
    lz_blank = 1'b1;
    step(36);
    for (int i = 0; i < 3; i++) wr(3'(i), 4'h0);
    step(36);
    dp_in = 8'h30;
    step(36);

    // Enable mask and decimal point.
    lz_blank = 1'b0;
    digit_en = 8'h0F;
    dp_in    = 8'h02;
    wr(3'd1, 4'h9);
    step(36);

    // Randomized traffic, biased toward zero values to exercise blanking.
    digit_en = '1;
    dp_in    = '0;
    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) begin
        digit_en = 8'($urandom);
        dp_in    = 8'($urandom);
        lz_blank = 1'($urandom);
      end
      wr_en   = ($urandom % 3) == 0;
      wr_addr = 3'($urandom);
      wr_data = ($urandom % 2) ? 4'h0 : 4'($urandom);
      step(1);
    end
    wr_en = 1'b0;

    // Asynchronous reset in the middle of digit 5's slot.
    digit_en = '1;
    dp_in    = '0;
    lz_blank = 1'b0;
    for (int i = 0; i < ND; i++) wr(3'(i), 4'(i + 8));
    for (int k = 0; k < 64 && !(((t / TD) % ND) == 5 && (t % TD) == 2); k++) step(1);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an, seg, dp} !== RST_VAL) begin
      n_fail++;
      $display("FAIL async_rst: got an=%h seg=%b dp=%b, need an=ff seg=1111111 dp=1",
               an, seg, dp);
    end
    step(2);
    rst_n = 1'b1;
    step(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. Holds one 4-bit hex value per digit and cycles through the digits at a fixed refresh rate. On each step it presents the current digit's value to a single shared `decoder_4_7` instance and drives that digit's anode. It sits between the register/bus logic that writes display values and the board's anode, segment and decimal-point pins.

## Interface
Parameters:
- `N_DIGITS`, default 8: number of digits scanned, range 2..8.
- `TICK_DIV`, default 100000: clock cycles per digit slot, minimum 2. At 100 MHz this gives 1 kHz per digit.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: write strobe for the digit register file.
- `wr_addr`, in, 3: digit index to write. Writes with `wr_addr >= N_DIGITS` are ignored.
- `wr_data`, in, 4: hex value to store.
- `digit_en`, in, N_DIGITS: per-digit enable, 1 = shown. A disabled digit keeps its anode off during its slot.
- `dp_in`, in, N_DIGITS: per-digit decimal point, 1 = lit.
- `lz_blank`, in, 1: leading-zero blanking enable.
- `an`, out, N_DIGITS: anode selects, active-low, registered.
- `seg`, out, 7: segments {a,b,c,d,e,f,g}, active-low, with `seg[6]` = a. Registered.
- `dp`, out, 1: decimal point, active-low, registered.

## Operation
- **Digit register file:** `digits[N_DIGITS]` × 4 bits, all 0 after reset. Written on a clock edge when `wr_en` = 1.
- **Divider:** `div_cnt` counts 0..TICK_DIV-1 and wraps. `tick` = (`div_cnt` == TICK_DIV-1).
- **Scan index:** `idx` increments on `tick` and wraps N_DIGITS-1 → 0.
- **Leading-zero mask:**
  - `msd` = index of the highest digit with a nonzero value, or 0 if all digits are 0.
  - When `lz_blank` = 1, digits with index > `msd` are blanked.
  - Digit 0 is never blanked by leading-zero logic.
  - A digit that is blanked but has `dp_in` = 1 still lights, showing only its dp (`seg` = 7'h7F, `dp` = 0).
- **Output register:** updated every cycle.
  - If `tick` = 1 (dead-time cycle): `an` = all 1s, `seg` = 7'h7F, `dp` = 1. This is anti-ghosting blanking.
  - Otherwise, if `digit_en[idx]` = 1 and the digit is not fully blanked: `an` = ~(1 << `idx`); `seg` = decode(`digits[idx]`), or 7'h7F if leading-zero blanked; `dp` = ~`dp_in[idx]`.
  - Otherwise: `an` = all 1s, `seg` = 7'h7F, `dp` = 1.
- **Reset values:** `div_cnt` = 0, `idx` = 0, `digits` = 0, `an` = all 1s, `seg` = 7'h7F, `dp` = 1.

## Timing
- Write in cycle k with `wr_addr` == `idx` and no tick: the new `seg` value appears after edge k+1 (two-edge latency).
- A digit slot lasts TICK_DIV cycles: 1 dead-time cycle followed by TICK_DIV-1 lit cycles.
- A full frame is N_DIGITS × TICK_DIV cycles.
- Changes to `digit_en`, `dp_in` or `lz_blank` take effect on outputs one edge later.
- **Write during the tick cycle:** the register file updates normally and the dead-time cycle is unaffected.
- **Reset asserted mid-scan:** all state and outputs return to reset values immediately (asynchronous). The first edge after release starts the slot for digit 0 with `div_cnt` = 0.
- **N_DIGITS < 8:** the index wraps at N_DIGITS-1. Unused `wr_addr` values are ignored.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - Digit value type, 4 bits.
  - Function `clog2` for the `idx` width.
- Sub-module: one `decoder_4_7` instance, fed by `digits[idx]`.
- All other logic (divider, index counter, register file, leading-zero mask, output register) lives in `seg_scan_ctrl`.

## Test plan
All scenarios use N_DIGITS = 8, TICK_DIV = 4.
- **Reset:** hold `rst_n` = 0 → `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1. After release, `an` = 8'hFE from edge 1 to edge 3, then `an` = 8'hFF for one cycle, then 8'hFD.
- **Full scan:** write digits 0..7 = 0..7, all digits enabled → over 32 cycles each anode goes low in turn. `seg` shows 7'b0000001 for digit 0 and 7'b0001111 for digit 7, and the index wraps back to digit 0.
- **Leading-zero blanking:** `digits` = {0,0,0,0,0,1,2,3} (digit 7 down to digit 0), `lz_blank` = 1 → digits 3..7 keep `an` high. All-zero value with `lz_blank` = 1 → only digit 0 lit, `seg` = 7'b0000001.
- **Mask and dp:** `digit_en` = 8'h0F, `dp_in` = 8'h02 → digits 4..7 dark; during digit 1's slot `dp` = 0.
- **Write latency:** while digit 2 is displayed, write `wr_addr` = 2, `wr_data` = 4'hA → `seg` = 7'b0001000 two edges after the write edge.
- **Async reset mid-frame:** assert `rst_n` = 0 during digit 5's slot → outputs go to reset values without waiting for a clock edge, and `digits` reads back as 0 on the next scan.
